c2f_dsc_reader: RTL
===================

C2F_DSC_READER -- requirements
Module: c2f_dsc_reader

Interface
REQ-001 SHALL have parameter RB_AWIDTH, default 10, log2 of the maximum CPU-to-FPGA descriptor ring entries.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (power of two, at least 8), descriptor output buffer entries.
REQ-003 Port pcie_clk  in  1  the single clock; all logic is synchronous to it.
REQ-004 Port pcie_reset_n  in  1  reset, asynchronous and active-low.
REQ-005 Port cfg_write  in  1  MMIO register write strobe.
REQ-006 Port cfg_addr  in  3  register index: 0 base_lo, 1 base_hi, 2 ring_size, 3 tail, 4 enable.
REQ-007 Port cfg_writedata  in  32  write data.
REQ-008 Ports pcie_bas_waitrequest in 1, pcie_bas_address out 64, pcie_bas_read out 1, pcie_bas_burstcount out 4, pcie_bas_readdata in 512, pcie_bas_readdatavalid in 1, pcie_bas_response in 2: the Avalon burst read master to host memory.
REQ-009 Port dsc_out_data  out  96  {length[31:0], buf_addr[63:0]}.
REQ-010 Ports dsc_out_valid out 1 and dsc_out_ready in 1: the descriptor stream handshake.
REQ-011 Port head  out  RB_AWIDTH+1  index of the next descriptor to be consumed.
REQ-012 Port rd_err_cnt  out  32  count of beats with a nonzero pcie_bas_response.

Function
REQ-013 Ring index arithmetic SHALL be modulo ring_size (a power of two), and descriptor i SHALL be read from base + i*64.
REQ-014 A write to tail SHALL mask the value to ring_size-1; a write equal to the current request pointer SHALL issue nothing.
REQ-015 FSM states: IDLE and REQ; IDLE->REQ when enable=1, req_ptr!=tail and credits>0; REQ->IDLE on the cycle read is accepted (pcie_bas_waitrequest=0).
REQ-016 burstcount SHALL be the minimum of 8, (tail-req_ptr) mod ring_size, entries up to the ring wrap, and credits; a burst SHALL never cross the wrap.
REQ-017 address, read and burstcount SHALL stay stable in REQ while pcie_bas_waitrequest=1.
REQ-018 credits SHALL equal FIFO_DEPTH minus FIFO occupancy minus outstanding beats; the FIFO SHALL never overflow.
REQ-019 Each readdatavalid beat SHALL push readdata[95:0] into the FIFO in return order.
REQ-020 Beats arriving while outstanding==0 SHALL be dropped.
REQ-021 Each beat with a nonzero response SHALL increment rd_err_cnt, and the beat SHALL still be forwarded.
REQ-022 head SHALL advance by 1 (with wrap) on each dsc_out_valid&&dsc_out_ready.
REQ-023 dsc_out_valid SHALL first rise one cycle after the first beat arrives.
REQ-024 When enable=0, no new burst SHALL start; outstanding beats SHALL complete and drain.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-026 A write to ring_size or base SHALL take effect only for bursts issued afterwards.

Reset
REQ-027 On pcie_reset_n low, the following SHALL clear to 0: FSM state (IDLE), req_ptr, head, tail, outstanding count, FIFO, registers, pcie_bas_read, dsc_out_valid and rd_err_cnt.
REQ-028 Reset asserted in the middle of a burst SHALL abandon that burst, and its late beats SHALL be dropped per REQ-020.

Configuration
REQ-029 With C2F_DSC_STATS_EN defined, the block SHALL add outputs dsc_cnt (32) and byte_cnt (64), accumulating consumed descriptors and their length fields, both cleared on reset.
REQ-030 Without C2F_DSC_STATS_EN, those ports and counters SHALL not exist.

Structure
REQ-031 The descriptor struct (buf_addr, length) and the register index constants SHALL live in the shared pcie_consts package.
REQ-032 The output buffer SHALL be one sub-module, c2f_dsc_fifo: show-ahead, with an occupancy output.

Verification
REQ-033 Case: base=0x1000, size=16, tail=3 -> one burst, addr 0x1000, burstcount 3; three descriptors out in order; head=3.
REQ-034 Case: req_ptr=14, size=16, tail=2 -> burst of 2 at base+0x380, then burst of 2 at base; head wraps to 2.
REQ-035 Case: dsc_out_ready=0, tail=40, size=64 -> at most 16 reads outstanding plus buffered; no overflow; all 40 delivered once ready=1.
REQ-036 Case: waitrequest held 5 cycles -> address, read and burstcount stable throughout; exactly one burst accepted.
REQ-037 Case: one beat with response=2 -> rd_err_cnt=1 and the descriptor is still delivered.
REQ-038 Case: reset asserted with 4 beats outstanding, then 4 stray beats arrive -> no dsc_out_valid; head=0.

Source files
------------

// File: rtl/c2f_dsc_reader_pkg.sv
// Shared PCIe constants: descriptor layout, MMIO register indices and reader FSM states.
package pcie_consts;

  typedef struct packed {
    logic [31:0] length;
    logic [63:0] buf_addr;
  } dsc_t;

  localparam logic [2:0] REG_BASE_LO   = 3'd0;
  localparam logic [2:0] REG_BASE_HI   = 3'd1;
  localparam logic [2:0] REG_RING_SIZE = 3'd2;
  localparam logic [2:0] REG_TAIL      = 3'd3;
  localparam logic [2:0] REG_ENABLE    = 3'd4;

  localparam int unsigned MAX_BURST = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/c2f_dsc_reader_if.sv
// Avalon burst-read master bus plus descriptor output stream of the C2F descriptor reader.
interface c2f_dsc_reader_if import pcie_consts::*; ();
    logic          pcie_bas_waitrequest;
    logic [63:0]   pcie_bas_address;
    logic          pcie_bas_read;
    logic [3:0]    pcie_bas_burstcount;
    logic [511:0]  pcie_bas_readdata;
    logic          pcie_bas_readdatavalid;
    logic [1:0]    pcie_bas_response;
    dsc_t          dsc_out_data;
    logic          dsc_out_valid;
    logic          dsc_out_ready;

    modport master (
        input  pcie_bas_waitrequest, pcie_bas_readdata, pcie_bas_readdatavalid,
               pcie_bas_response, dsc_out_ready,
        output pcie_bas_address, pcie_bas_read, pcie_bas_burstcount,
               dsc_out_data, dsc_out_valid
    );

    modport slave (
        output pcie_bas_waitrequest, pcie_bas_readdata, pcie_bas_readdatavalid,
               pcie_bas_response, dsc_out_ready,
        input  pcie_bas_address, pcie_bas_read, pcie_bas_burstcount,
               dsc_out_data, dsc_out_valid
    );
endinterface

// File: rtl/c2f_dsc_reader_fifo.sv
// Show-ahead descriptor buffer with occupancy output; a push while full is only taken with a pop.
module c2f_dsc_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    assign dout      = r_mem[r_rptr];
    assign valid     = (r_count != '0);
    assign occupancy = r_count;
endmodule

// File: rtl/c2f_dsc_reader.sv
// CPU-to-FPGA descriptor ring reader: bursts descriptors from host memory into a credit-limited FIFO.
// Optional C2F_DSC_STATS_EN adds consumed-descriptor and byte counters.
module c2f_dsc_reader import pcie_consts::*; #(
    parameter int unsigned RB_AWIDTH  = 10,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  pcie_clk,
    input  logic                  pcie_reset_n,
    input  logic                  cfg_write,
    input  logic [2:0]            cfg_addr,
    input  logic [31:0]           cfg_writedata,
    c2f_dsc_reader_if.master      bus,
    output logic [RB_AWIDTH:0]    head,
    output logic [31:0]           rd_err_cnt
`ifdef C2F_DSC_STATS_EN
    ,
    output logic [31:0]           dsc_cnt,
    output logic [63:0]           byte_cnt
`endif
);
    localparam int unsigned IW = RB_AWIDTH + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e      r_state, w_state_nxt;
    logic [63:0]    r_base, r_addr;
    logic [IW-1:0]  r_size, r_tail, r_req_ptr, r_head, r_mask_lat;
    logic           r_en;
    logic [3:0]     r_burst;
    logic [CW-1:0]  r_outst;
    logic [31:0]    r_err_cnt;

    logic [IW-1:0]  w_mask, w_avail, w_to_wrap, w_burst_calc;
    logic [CW-1:0]  w_occ, w_credits;
    logic           w_issue, w_accept, w_beat_ok, w_pop, w_fifo_valid;
    logic           w_unused_bits;

    assign w_mask    = r_size - 1'b1;
    assign w_avail   = (r_tail - r_req_ptr) & w_mask;
    assign w_to_wrap = r_size - r_req_ptr;
    assign w_credits = CW'(FIFO_DEPTH) - w_occ - r_outst;
    assign w_beat_ok = bus.pcie_bas_readdatavalid && (r_outst != '0);
    assign w_pop     = w_fifo_valid && bus.dsc_out_ready;
    assign w_unused_bits = ^{bus.pcie_bas_readdata[511:96], cfg_writedata[31:IW]};

    // Burst stops at the smallest of: max burst, pending entries, ring wrap, free credits.
    always_comb begin
        w_burst_calc = IW'(MAX_BURST);
        if (w_avail < w_burst_calc)          w_burst_calc = w_avail;
        if (w_to_wrap < w_burst_calc)        w_burst_calc = w_to_wrap;
        if (IW'(w_credits) < w_burst_calc)   w_burst_calc = IW'(w_credits);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: if (r_en && (w_avail != '0) && (w_credits != '0)) begin
                w_issue     = 1'b1;
                w_state_nxt = REQ;
            end
            REQ: if (!bus.pcie_bas_waitrequest) begin
                w_accept    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_size     <= '0;
            r_tail     <= '0;
            r_en       <= 1'b0;
            r_req_ptr  <= '0;
            r_head     <= '0;
            r_mask_lat <= '0;
            r_addr     <= '0;
            r_burst    <= '0;
            r_outst    <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (cfg_write) begin
                case (cfg_addr)
                    REG_BASE_LO:   r_base[31:0]  <= cfg_writedata;
                    REG_BASE_HI:   r_base[63:32] <= cfg_writedata;
                    REG_RING_SIZE: r_size        <= cfg_writedata[IW-1:0];
                    REG_TAIL:      r_tail        <= cfg_writedata[IW-1:0] & w_mask;
                    REG_ENABLE:    r_en          <= cfg_writedata[0];
                    default: ;
                endcase
            end
            // Geometry is latched at issue so later ring_size/base writes only affect new bursts.
            if (w_issue) begin
                r_addr     <= r_base + 64'({r_req_ptr, 6'b0});
                r_burst    <= w_burst_calc[3:0];
                r_mask_lat <= w_mask;
            end
            if (w_accept) r_req_ptr <= (r_req_ptr + IW'(r_burst)) & r_mask_lat;
            r_outst <= r_outst + (w_accept ? CW'(r_burst) : '0) - (w_beat_ok ? CW'(1) : '0);
            if (w_beat_ok && (bus.pcie_bas_response != 2'b00)) r_err_cnt <= r_err_cnt + 1'b1;
            if (w_pop) r_head <= (r_head + 1'b1) & w_mask;
        end
    end

    c2f_dsc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(dsc_t))
    ) u_fifo (
        .clk       (pcie_clk),
        .rst_n     (pcie_reset_n),
        .push      (w_beat_ok),
        .din       (bus.pcie_bas_readdata[95:0]),
        .pop       (w_pop),
        .dout      (bus.dsc_out_data),
        .valid     (w_fifo_valid),
        .occupancy (w_occ)
    );

    assign bus.dsc_out_valid       = w_fifo_valid;
    assign bus.pcie_bas_read       = (r_state == REQ);
    assign bus.pcie_bas_address    = r_addr;
    assign bus.pcie_bas_burstcount = r_burst;
    assign head                    = r_head;
    assign rd_err_cnt              = r_err_cnt;

`ifdef C2F_DSC_STATS_EN
    logic [31:0] r_dsc_cnt;
    logic [63:0] r_byte_cnt;

    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            r_dsc_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (w_pop) begin
            r_dsc_cnt  <= r_dsc_cnt + 1'b1;
            r_byte_cnt <= r_byte_cnt + 64'(bus.dsc_out_data.length);
        end
    end

    assign dsc_cnt  = r_dsc_cnt;
    assign byte_cnt = r_byte_cnt;
`endif
endmodule
